uart_ahb_ctrl: RTL and testbench

//  AHB-Lite slave controller between the system bus and the uart_tx/uart_rx datapath.

---
 rtl/uart_ahb_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_ahb_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ahb_ctrl.sv
// uart_ahb_ctrl
//   AHB-Lite slave that fronts the uart_tx / uart_rx datapath. It decodes a
//   four-word register window, buffers TX and RX bytes in small FIFOs, inserts
//   wait states when a DATA write meets a full TX FIFO, and keeps sticky
//   error status.
//
//   Register map (haddr_i[3:2]):
//     0 DATA   : write pushes byte to TX FIFO, read pops RX FIFO (0 if empty)
//     1 STATUS : [0] txfull [1] txempty [2] rxempty [3] rxfull
//                [4] OVR [5] FRM [6] DROP (sticky, write 1 to clear)
//     2 CTRL   : [15:0] prescale, [16] irq enable
//     3 -      : two-cycle ERROR response
//
//   Ports
//     hclk, hrst_n              clock, async active-low reset
//     hsel_i .. hready_i        AHB-Lite slave inputs
//     hrdata_o/hready_o/hresp_o AHB-Lite slave outputs
//     tx_data_o/tx_valid_o/tx_ready_i   byte stream to uart_tx
//     rx_data_i/rx_valid_i/rx_ready_o   byte stream from uart_rx
//     rx_overrun_i, rx_frame_i          error pulses from uart_rx
//     prescale_o                        baud divisor
//     irq_o                             interrupt (only with UART_CTRL_IRQ_EN)
//
//   Optional feature macro: UART_CTRL_IRQ_EN adds the registered irq_o output
//   and makes CTRL[16] writable. Without it CTRL[16] reads 0.

module uart_ahb_ctrl #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd434
) (
  input  logic                  hclk,
  input  logic                  hrst_n,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic [1:0]            hresp_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  input  logic                  rx_overrun_i,
  input  logic                  rx_frame_i,
  output logic [15:0]           prescale_o
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t      r_state, w_next;
  logic        w_ready;
  logic [1:0]  w_resp;

  logic [1:0]  r_addr;
  logic        r_write;
  logic [7:0]  r_wbyte;

  logic        w_aphase;
  logic [31:0] w_wdata;
  logic        w_dp, w_rd, w_wr_data, w_rd_data, w_wr_stat, w_wr_ctrl;

  // TX FIFO
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [PW:0] r_tx_wp, r_tx_rp;
  logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [7:0]  w_tx_byte;

  // RX FIFO
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [PW:0] r_rx_wp, r_rx_rp;
  logic        w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_drop_set;
  logic [7:0]  w_rx_head;

  // status / control
  logic        r_ovr, r_frm, r_drop;
  logic [15:0] r_prescale;
  logic        w_irq_en;
  logic [31:0] w_rd32;

  // Only haddr_i[3:2], htrans_i[1] and the low word of hwdata_i matter.
  logic        w_unused;
  assign w_unused = ^{haddr_i, hsize_i, htrans_i[0], w_wdata[31:16]};

  assign w_aphase = hsel_i & htrans_i[1] & hready_i;
  assign w_wdata  = 32'(hwdata_i);

  // Data-phase strobes; S_DATA never holds address 3 (that goes to S_ERR1).
  assign w_dp      = (r_state == S_DATA);
  assign w_rd      = w_dp & ~r_write;
  assign w_wr_data = w_dp &  r_write & (r_addr == 2'd0);
  assign w_rd_data = w_dp & ~r_write & (r_addr == 2'd0);
  assign w_wr_stat = w_dp &  r_write & (r_addr == 2'd1);
  assign w_wr_ctrl = w_dp &  r_write & (r_addr == 2'd2);

  //--------------------------------------------------------------------------
  // Bus FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b1;
    w_resp  = 2'b00;
    case (r_state)
      S_IDLE: ;
      S_DATA: begin
        if (w_wr_data & w_tx_full) begin
          w_ready = 1'b0;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: w_ready = ~w_tx_full;
      S_ERR1: begin
        w_ready = 1'b0;
        w_resp  = 2'b01;
        w_next  = S_ERR2;
      end
      S_ERR2: w_resp = 2'b01;
      default: w_next = S_IDLE;
    endcase
    // Whenever this cycle completes a transfer, a pipelined address phase
    // may already be on the bus and decides the next data phase.
    if (w_ready) begin
      if (w_aphase) w_next = (haddr_i[3:2] == 2'd3) ? S_ERR1 : S_DATA;
      else          w_next = S_IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_addr  <= 2'd0;
      r_write <= 1'b0;
      r_wbyte <= 8'd0;
    end else begin
      if (w_aphase & w_ready) begin
        r_addr  <= haddr_i[3:2];
        r_write <= hwrite_i;
      end
      // Hold the stalled byte so the push does not depend on hwdata_i later.
      if (w_wr_data & w_tx_full) r_wbyte <= w_wdata[7:0];
    end
  end

  assign hready_o = w_ready;
  assign hresp_o  = w_resp;

  //--------------------------------------------------------------------------
  // TX FIFO
  //--------------------------------------------------------------------------
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[PW] != r_tx_rp[PW]) &&
                      (r_tx_wp[PW-1:0] == r_tx_rp[PW-1:0]);
  // Pushes are gated by ~full, so a full FIFO never sees push+pop together.
  assign w_tx_push  = (w_wr_data | (r_state == S_WAIT)) & ~w_tx_full;
  assign w_tx_byte  = (r_state == S_WAIT) ? r_wbyte : w_wdata[7:0];
  assign w_tx_pop   = ~w_tx_empty & tx_ready_i;

  always_ff @(posedge hclk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[PW-1:0]] <= w_tx_byte;
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
    end
  end

  assign tx_valid_o = ~w_tx_empty;
  assign tx_data_o  = r_tx_mem[r_tx_rp[PW-1:0]];

  //--------------------------------------------------------------------------
  // RX FIFO
  //--------------------------------------------------------------------------
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[PW] != r_rx_rp[PW]) &&
                      (r_rx_wp[PW-1:0] == r_rx_rp[PW-1:0]);
  assign w_rx_pop   = w_rd_data & ~w_rx_empty;
  // On a full FIFO a same-cycle pop frees the slot being written.
  assign w_rx_push  = rx_valid_i & (~w_rx_full | w_rx_pop);
  assign w_drop_set = rx_valid_i & w_rx_full & ~w_rx_pop;
  assign w_rx_head  = w_rx_empty ? 8'd0 : r_rx_mem[r_rx_rp[PW-1:0]];

  always_ff @(posedge hclk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[PW-1:0]] <= rx_data_i;
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  assign rx_ready_o = 1'b1;

  //--------------------------------------------------------------------------
  // Sticky status (set wins over a same-cycle clear) and control
  //--------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_ovr  <= 1'b0;
      r_frm  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_ovr  <= rx_overrun_i | (r_ovr  & ~(w_wr_stat & w_wdata[4]));
      r_frm  <= rx_frame_i   | (r_frm  & ~(w_wr_stat & w_wdata[5]));
      r_drop <= w_drop_set   | (r_drop & ~(w_wr_stat & w_wdata[6]));
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n)        r_prescale <= PRESCALE_RST;
    else if (w_wr_ctrl) r_prescale <= w_wdata[15:0];
  end

  assign prescale_o = r_prescale;

`ifdef UART_CTRL_IRQ_EN
  logic r_irq_en, r_irq;

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= w_wdata[16];
      r_irq <= r_irq_en & (~w_rx_empty | w_tx_empty | r_ovr | r_frm | r_drop);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq_o    = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Read data: combinational during the data phase, 0 otherwise
  //--------------------------------------------------------------------------
  always_comb begin
    w_rd32 = 32'd0;
    case (r_addr)
      2'd0: w_rd32 = {24'd0, w_rx_head};
      2'd1: w_rd32 = {25'd0, r_drop, r_frm, r_ovr, w_rx_full, w_rx_empty,
                      w_tx_empty, w_tx_full};
      2'd2: w_rd32 = {15'd0, w_irq_en, r_prescale};
      default: w_rd32 = 32'd0;
    endcase
  end

  assign hrdata_o = w_rd ? DATA_WIDTH'(w_rd32) : '0;

endmodule

// File: tb/tb_uart_ahb_ctrl.sv
module tb_uart_ahb_ctrl;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] hwdata_i;
  logic [31:0] hrdata_o;
  logic        hready_o;
  logic [1:0]  hresp_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        rx_overrun_i;
  logic        rx_frame_i;
  logic [15:0] prescale_o;
`ifdef UART_CTRL_IRQ_EN
  logic        irq_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] txq[$];

  always #5 hclk = ~hclk;

  uart_ahb_ctrl dut (
    .hclk(hclk), .hrst_n(hrst_n), .hsel_i(hsel_i), .haddr_i(haddr_i),
    .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i),
    .hwdata_i(hwdata_i), .hready_i(hready_o), .hrdata_o(hrdata_o),
    .hready_o(hready_o), .hresp_o(hresp_o), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rx_overrun_i(rx_overrun_i), .rx_frame_i(rx_frame_i),
    .prescale_o(prescale_o)
`ifdef UART_CTRL_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  // Record every byte handed to uart_tx, sampled mid-cycle.
  always @(negedge hclk) begin
    #1;
    if (hrst_n && tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One non-pipelined transfer. Optional overrun pulse during the data phase.
  task automatic ahb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     input logic p_ovr, output logic [31:0] rd,
                     output logic [1:0] r0, output logic [1:0] r1, output int w);
    @(negedge hclk);
    hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = {28'd0, a}; hwrite_i = wr;
    @(negedge hclk);
    hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = wd; rx_overrun_i = p_ovr;
    r0 = hresp_o;
    w  = 0;
    while (!hready_o && w < 20) begin
      @(negedge hclk);
      w++;
    end
    rd = hrdata_o;
    r1 = hresp_o;
    @(negedge hclk);
    rx_overrun_i = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  r0, r1;
  int          w;

  initial begin
    hrst_n = 1'b0; hsel_i = 1'b0; haddr_i = '0; htrans_i = '0; hwrite_i = 1'b0;
    hsize_i = 3'b010; hwdata_i = '0; tx_ready_i = 1'b0; rx_data_i = '0;
    rx_valid_i = 1'b0; rx_overrun_i = 1'b0; rx_frame_i = 1'b0;
    repeat (2) @(negedge hclk);

    // reset state
    chk("rst_hready", {31'd0, hready_o}, 32'd1);
    chk("rst_hresp", {30'd0, hresp_o}, 32'd0);
    chk("rst_hrdata", hrdata_o, 32'd0);
    chk("rst_txvalid", {31'd0, tx_valid_o}, 32'd0);
    chk("rst_prescale", {16'd0, prescale_o}, 32'd434);
    hrst_n = 1'b1;
    chk("rx_ready", {31'd0, rx_ready_o}, 32'd1);

    ahb(1'b0, 4'h8, 0, 1'b0, rd, r0, r1, w);
    chk("ctrl_rst", rd, 32'h0000_01B2);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("stat_rst", rd, 32'h06);
    chk("stat_rst_waits", w, 0);

    // TX 0x41, 0x42 with uart_tx ready
    tx_ready_i = 1'b1;
    ahb(1'b1, 4'h0, 32'h41, 1'b0, rd, r0, r1, w);
    ahb(1'b1, 4'h0, 32'h42, 1'b0, rd, r0, r1, w);
    repeat (3) @(negedge hclk);
    chk("tx_cnt2", txq.size(), 2);
    chk("tx_b0", {24'd0, txq[0]}, 32'h41);
    chk("tx_b1", {24'd0, txq[1]}, 32'h42);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("stat_txempty", rd, 32'h06);
    txq.delete();

    // fill TX FIFO, 5th write stalls
    tx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ahb(1'b1, 4'h0, 32'h51 + i, 1'b0, rd, r0, r1, w);
      chk("fill_waits", w, 0);
    end
    @(negedge hclk);
    hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0; hwrite_i = 1'b1;
    @(negedge hclk);
    hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = 32'h55;
    chk("stall_dp", {31'd0, hready_o}, 32'd0);
    @(negedge hclk);
    chk("stall_wait", {31'd0, hready_o}, 32'd0);
    tx_ready_i = 1'b1;
    @(negedge hclk);
    tx_ready_i = 1'b0;
    chk("wait_done", {31'd0, hready_o}, 32'd1);
    @(negedge hclk);
    chk("one_popped", txq.size(), 1);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("stat_txfull", rd, 32'h05);
    tx_ready_i = 1'b1;
    repeat (6) @(negedge hclk);
    tx_ready_i = 1'b0;
    chk("drain_cnt", txq.size(), 5);
    for (int i = 0; i < 5; i++) chk("drain_byte", {24'd0, txq[i]}, 32'h51 + i);
    txq.delete();

    // RX: 5 bytes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      rx_valid_i = 1'b1; rx_data_i = 8'h10 + 8'(i);
    end
    @(negedge hclk);
    rx_valid_i = 1'b0;
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("stat_drop", rd, 32'h4A);
    for (int i = 0; i < 4; i++) begin
      ahb(1'b0, 4'h0, 0, 1'b0, rd, r0, r1, w);
      chk("rx_byte", rd, 32'h10 + i);
    end
    ahb(1'b0, 4'h0, 0, 1'b0, rd, r0, r1, w);
    chk("rx_empty_rd", rd, 32'h0);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("stat_rxempty", rd, 32'h46);
    ahb(1'b1, 4'h4, 32'h40, 1'b0, rd, r0, r1, w);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("drop_clr", rd, 32'h06);

    // OVR/FRM sticky, set wins over clear
    @(negedge hclk);
    rx_overrun_i = 1'b1; rx_frame_i = 1'b1;
    @(negedge hclk);
    rx_overrun_i = 1'b0; rx_frame_i = 1'b0;
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("stat_ovr_frm", rd, 32'h36);
    ahb(1'b1, 4'h4, 32'h30, 1'b1, rd, r0, r1, w);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("set_wins", rd, 32'h16);
    ahb(1'b1, 4'h4, 32'h10, 1'b0, rd, r0, r1, w);
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("ovr_clr", rd, 32'h06);

    // unmapped address
    ahb(1'b0, 4'hC, 0, 1'b0, rd, r0, r1, w);
    chk("err_resp1", {30'd0, r0}, 32'd1);
    chk("err_resp2", {30'd0, r1}, 32'd1);
    chk("err_waits", w, 1);
    ahb(1'b0, 4'h8, 0, 1'b0, rd, r0, r1, w);
    chk("after_err_resp", {30'd0, r1}, 32'd0);
    chk("after_err_waits", w, 0);

    // CTRL write
    ahb(1'b1, 4'h8, 32'h0001_0064, 1'b0, rd, r0, r1, w);
    chk("prescale_wr", {16'd0, prescale_o}, 32'h64);
    ahb(1'b0, 4'h8, 0, 1'b0, rd, r0, r1, w);
`ifdef UART_CTRL_IRQ_EN
    chk("ctrl_rd", rd, 32'h0001_0064);
`else
    chk("ctrl_rd", rd, 32'h0000_0064);
`endif

    // queue one TX byte so txempty is 0
    ahb(1'b1, 4'h0, 32'h77, 1'b0, rd, r0, r1, w);
    chk("tx_queued", {31'd0, tx_valid_o}, 32'd1);

`ifdef UART_CTRL_IRQ_EN
    @(negedge hclk);
    chk("irq_idle", {31'd0, irq_o}, 32'd0);
    rx_frame_i = 1'b1;
    @(negedge hclk);
    rx_frame_i = 1'b0;
    @(negedge hclk);
    chk("irq_frm", {31'd0, irq_o}, 32'd1);
    ahb(1'b1, 4'h4, 32'h20, 1'b0, rd, r0, r1, w);
    @(negedge hclk);
    chk("irq_clr", {31'd0, irq_o}, 32'd0);
`endif

    // asynchronous reset mid-operation
    #3;
    hrst_n = 1'b0;
    #1;
    chk("arst_txvalid", {31'd0, tx_valid_o}, 32'd0);
    chk("arst_prescale", {16'd0, prescale_o}, 32'd434);
    @(negedge hclk);
    hrst_n = 1'b1;
    ahb(1'b0, 4'h4, 0, 1'b0, rd, r0, r1, w);
    chk("arst_stat", rd, 32'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
